alarm_multi_ctrl: RTL and testbench
===================================

ALARM_MULTI_CTRL -- requirements
Module: alarm_multi_ctrl

Interface
REQ-001 Parameter NUM_ALARMS, default 4: number of independent alarm slots (1..16).
REQ-002 Parameter SNOOZE_MIN, default 9: snooze delay in minutes (1..59).
REQ-003 Parameter RING_TIMEOUT_SEC, default 60: seconds an alarm rings before auto-stop (1..255).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sec_tick  input  1  one-cycle pulse; hr/min/sec hold the new time in that cycle.
REQ-007 hr / min / sec  input  5 / 6 / 6  current time, 24-h format.
REQ-008 wr_en  input  1  slot write strobe.
REQ-009 wr_idx  input  clog2(NUM_ALARMS), min 1  slot to write.
REQ-010 wr_hr / wr_min / wr_arm  input  5 / 6 / 1  alarm time and arm bit for written slot.
REQ-011 snooze  input  1  one-cycle pulse: snooze all ringing slots.
REQ-012 alarm_clear  input  1  one-cycle pulse: stop all ringing and snoozed slots.
REQ-013 alarm_active  output  1  OR of all slot ringing flags.
REQ-014 ring_mask  output  NUM_ALARMS  per-slot ringing flag.
REQ-015 timeout_pulse  output  1  one-cycle pulse when any slot auto-stops.

Function
REQ-016 Each slot holds alarm_hr, alarm_min, armed, snooze_hr, snooze_min, state, 8-bit ring counter.
REQ-017 Slot states: IDLE, RINGING, SNOOZED; ring_mask[i] = (state_i == RINGING), combinational from state.
REQ-018 wr_en writes slot wr_idx on the edge; written slot forced to IDLE, ring counter cleared; other slots unaffected.
REQ-019 Match_i = armed_i && sec_tick && hr==alarm_hr_i && min==alarm_min_i && sec==0.
REQ-020 IDLE -> RINGING on Match_i; ring_mask[i] asserts the cycle after the tick (1-cycle latency).
REQ-021 RINGING: ring counter increments on each sec_tick; when counter reaches RING_TIMEOUT_SEC on a tick -> IDLE, timeout_pulse high for exactly the next cycle.
REQ-022 RINGING + snooze -> SNOOZED; snooze target = current hr:min + SNOOZE_MIN, minute wraps at 60 carrying into hour, hour wraps 23 -> 0.
REQ-023 SNOOZED -> RINGING on sec_tick with hr==snooze_hr, min==snooze_min, sec==0; ring counter restarts at 0.
REQ-024 snooze ignored by IDLE and SNOOZED slots; repeated snoozes unlimited.
REQ-025 alarm_clear: every RINGING or SNOOZED slot -> IDLE, counters cleared; armed bits and alarm times retained.
REQ-026 Priority per slot in one cycle: wr_en (to that slot) > alarm_clear > snooze > timeout > match.
REQ-027 Slot already RINGING or SNOOZED ignores its own Match_i (no restart of counter).
REQ-028 Clearing armed via write while SNOOZED cancels the snooze (slot IDLE per REQ-018).
REQ-029 Multiple slots may ring simultaneously; each is independent except shared snooze/clear.
REQ-030 wr_idx >= NUM_ALARMS: write ignored.
REQ-031 Inputs hr/min/sec out of range (hr>23, min/sec>59) never generate snooze targets; no match check beyond equality.

Reset
REQ-032 rst_n low: all slots IDLE, armed=0, alarm and snooze times 0, counters 0; alarm_active=0, ring_mask=0, timeout_pulse=0, immediately without clock.
REQ-033 rst_n deassertion mid-ring: block resumes from reset state; no ringing until a slot is re-written and armed.

Verification
REQ-034 Slot 1 armed 07:30; tick at 07:30:00 -> ring_mask=4'b0010, alarm_active=1 next cycle; tick at 07:30:01 does not retrigger.
REQ-035 Slot 0 ringing at 23:55, snooze -> SNOOZED, target 00:04; tick 00:04:00 -> ring_mask[0]=1.
REQ-036 Slot 2 ringing, 60 sec_ticks, no user input -> slot IDLE, timeout_pulse one cycle, alarm_active=0.
REQ-037 Slots 0 and 3 both 06:00; both ring; snooze and alarm_clear same cycle -> both IDLE (clear wins), armed retained, re-ring next day 06:00:00.
REQ-038 Slot 1 ringing; wr_en to slot 1 and snooze same cycle -> slot 1 IDLE with new time; other ringing slot enters SNOOZED.
REQ-039 rst_n pulsed low while slot 0 SNOOZED -> all outputs 0 asynchronously; snooze target time passes with no ringing.

Source files
------------

// File: rtl/alarm_multi_ctrl.sv
// Multi-slot alarm controller: each slot matches wall-clock time, rings, snoozes
// or times out independently; snooze and clear act on every slot at once.
module alarm_multi_ctrl #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_SEC = 60,
    localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sec_tick,
    input  logic [4:0]            hr,
    input  logic [5:0]            min,
    input  logic [5:0]            sec,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [4:0]            wr_hr,
    input  logic [5:0]            wr_min,
    input  logic                  wr_arm,
    input  logic                  snooze,
    input  logic                  alarm_clear,
    output logic                  alarm_active,
    output logic [NUM_ALARMS-1:0] ring_mask,
    output logic                  timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } slot_state_t;

    slot_state_t state_q      [NUM_ALARMS];
    slot_state_t state_d      [NUM_ALARMS];
    logic [4:0]  alarm_hr_q   [NUM_ALARMS];
    logic [4:0]  alarm_hr_d   [NUM_ALARMS];
    logic [5:0]  alarm_min_q  [NUM_ALARMS];
    logic [5:0]  alarm_min_d  [NUM_ALARMS];
    logic        armed_q      [NUM_ALARMS];
    logic        armed_d      [NUM_ALARMS];
    logic [4:0]  snooze_hr_q  [NUM_ALARMS];
    logic [4:0]  snooze_hr_d  [NUM_ALARMS];
    logic [5:0]  snooze_min_q [NUM_ALARMS];
    logic [5:0]  snooze_min_d [NUM_ALARMS];
    logic [7:0]  ring_cnt_q   [NUM_ALARMS];
    logic [7:0]  ring_cnt_d   [NUM_ALARMS];
    logic        wr_hit       [NUM_ALARMS];
    logic        alarm_match  [NUM_ALARMS];
    logic        snooze_match [NUM_ALARMS];

    logic        timeout_any;
    logic        snz_valid;
    logic [6:0]  min_sum;
    logic        hr_carry;
    logic [5:0]  snz_min;
    logic [4:0]  snz_hr;

    // Snooze target shared by all slots; an out-of-range wall clock never yields one.
    always_comb begin
        snz_valid = (hr <= 5'd23) && (min <= 6'd59);
        min_sum   = {1'b0, min} + 7'(SNOOZE_MIN);
        hr_carry  = (min_sum >= 7'd60);
        snz_min   = hr_carry ? 6'(min_sum - 7'd60) : min_sum[5:0];
        if (!hr_carry) begin
            snz_hr = hr;
        end else if (hr == 5'd23) begin
            snz_hr = 5'd0;
        end else begin
            snz_hr = hr + 5'd1;
        end
    end

    // Per-slot next state; priority is write > clear > snooze > timeout > match.
    always_comb begin
        timeout_any = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i]      = state_q[i];
            alarm_hr_d[i]   = alarm_hr_q[i];
            alarm_min_d[i]  = alarm_min_q[i];
            armed_d[i]      = armed_q[i];
            snooze_hr_d[i]  = snooze_hr_q[i];
            snooze_min_d[i] = snooze_min_q[i];
            ring_cnt_d[i]   = ring_cnt_q[i];

            wr_hit[i]       = wr_en && (int'(wr_idx) == i);
            alarm_match[i]  = armed_q[i] && sec_tick && (hr == alarm_hr_q[i]) &&
                              (min == alarm_min_q[i]) && (sec == 6'd0);
            snooze_match[i] = sec_tick && (hr == snooze_hr_q[i]) &&
                              (min == snooze_min_q[i]) && (sec == 6'd0);

            if (wr_hit[i]) begin
                alarm_hr_d[i]  = wr_hr;
                alarm_min_d[i] = wr_min;
                armed_d[i]     = wr_arm;
                state_d[i]     = IDLE;
                ring_cnt_d[i]  = 8'd0;
            end else if (alarm_clear) begin
                state_d[i]     = IDLE;
                ring_cnt_d[i]  = 8'd0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (alarm_match[i]) begin
                            state_d[i]    = RINGING;
                            ring_cnt_d[i] = 8'd0;
                        end
                    end
                    RINGING: begin
                        if (snooze && snz_valid) begin
                            state_d[i]      = SNOOZED;
                            snooze_hr_d[i]  = snz_hr;
                            snooze_min_d[i] = snz_min;
                            ring_cnt_d[i]   = 8'd0;
                        end else if (sec_tick) begin
                            if (ring_cnt_q[i] == 8'(RING_TIMEOUT_SEC - 1)) begin
                                state_d[i]    = IDLE;
                                ring_cnt_d[i] = 8'd0;
                                timeout_any   = 1'b1;
                            end else begin
                                ring_cnt_d[i] = ring_cnt_q[i] + 8'd1;
                            end
                        end
                    end
                    SNOOZED: begin
                        if (snooze_match[i]) begin
                            state_d[i]    = RINGING;
                            ring_cnt_d[i] = 8'd0;
                        end
                    end
                    default: begin
                        state_d[i]    = IDLE;
                        ring_cnt_d[i] = 8'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]      <= IDLE;
                alarm_hr_q[i]   <= 5'd0;
                alarm_min_q[i]  <= 6'd0;
                armed_q[i]      <= 1'b0;
                snooze_hr_q[i]  <= 5'd0;
                snooze_min_q[i] <= 6'd0;
                ring_cnt_q[i]   <= 8'd0;
            end
            timeout_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]      <= state_d[i];
                alarm_hr_q[i]   <= alarm_hr_d[i];
                alarm_min_q[i]  <= alarm_min_d[i];
                armed_q[i]      <= armed_d[i];
                snooze_hr_q[i]  <= snooze_hr_d[i];
                snooze_min_q[i] <= snooze_min_d[i];
                ring_cnt_q[i]   <= ring_cnt_d[i];
            end
            timeout_pulse <= timeout_any;
        end
    end

    always_comb begin
        ring_mask = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ring_mask[i] = (state_q[i] == RINGING);
        end
    end

    assign alarm_active = |ring_mask;

endmodule

// File: tb/tb_alarm_multi_ctrl.sv
// Scoreboard bench for alarm_multi_ctrl: directed scenarios push expected output
// snapshots; a negedge monitor pops and compares them against the DUT.
module tb_alarm_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sec_tick, wr_en, wr_arm, snooze, alarm_clear;
    logic [4:0] hr, wr_hr;
    logic [5:0] min, sec, wr_min;
    logic [1:0] wr_idx;
    logic       alarm_active, timeout_pulse;
    logic [3:0] ring_mask;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic       active;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   failures = 0;

    alarm_multi_ctrl #(
        .NUM_ALARMS(4),
        .SNOOZE_MIN(9),
        .RING_TIMEOUT_SEC(60)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sec_tick(sec_tick),
        .hr(hr),
        .min(min),
        .sec(sec),
        .wr_en(wr_en),
        .wr_idx(wr_idx),
        .wr_hr(wr_hr),
        .wr_min(wr_min),
        .wr_arm(wr_arm),
        .snooze(snooze),
        .alarm_clear(alarm_clear),
        .alarm_active(alarm_active),
        .ring_mask(ring_mask),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: every queued expectation is compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (ring_mask !== e.mask || alarm_active !== e.active || timeout_pulse !== e.to) begin
                failures++;
                $display("[TB] FAIL %s: got ring_mask=%b alarm_active=%b timeout_pulse=%b, expected %b %b %b",
                         e.name, ring_mask, alarm_active, timeout_pulse, e.mask, e.active, e.to);
            end
        end
    end

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hr  = h;
        min = m;
        sec = s;
    endtask

    task automatic set_write(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                             input logic arm);
        wr_idx = idx;
        wr_hr  = h;
        wr_min = m;
        wr_arm = arm;
    endtask

    task automatic applyStimulus(input logic t, input logic snz, input logic clr, input logic we);
        sec_tick    = t;
        snooze      = snz;
        alarm_clear = clr;
        wr_en       = we;
        @(posedge clk);
        #1;
        sec_tick    = 1'b0;
        snooze      = 1'b0;
        alarm_clear = 1'b0;
        wr_en       = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] mask, input logic to);
        exp_t e;
        e.name   = name;
        e.mask   = mask;
        e.active = |mask;
        e.to     = to;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_time(h, m, s);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m,
                              input logic arm);
        set_write(idx, h, m, arm);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sec_tick = 1'b0; wr_en = 1'b0; snooze = 1'b0; alarm_clear = 1'b0;
        set_time(5'd0, 6'd0, 6'd0);
        set_write(2'd0, 5'd0, 6'd0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 4'b0000, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Slot 1 at 07:30, no retrigger on the following second
        write_slot(2'd1, 5'd7, 6'd30, 1'b1);
        checkOutput("write_no_ring", 4'b0000, 1'b0);
        tick_at(5'd7, 6'd29, 6'd59);
        checkOutput("s1_before_time", 4'b0000, 1'b0);
        tick_at(5'd7, 6'd30, 6'd0);
        checkOutput("s1_ring", 4'b0010, 1'b0);
        tick_at(5'd7, 6'd30, 6'd1);
        checkOutput("s1_no_retrigger", 4'b0010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("s1_clear", 4'b0000, 1'b0);

        // Slot 0 snoozed across midnight: 23:55 + 9 -> 00:04
        write_slot(2'd0, 5'd23, 6'd55, 1'b1);
        tick_at(5'd23, 6'd55, 6'd0);
        checkOutput("s0_ring_2355", 4'b0001, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s0_snoozed", 4'b0000, 1'b0);
        tick_at(5'd0, 6'd3, 6'd0);
        checkOutput("s0_snz_early", 4'b0000, 1'b0);
        tick_at(5'd0, 6'd4, 6'd0);
        checkOutput("s0_snz_ring_0004", 4'b0001, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("s0_clear", 4'b0000, 1'b0);

        // Slot 2 times out after 60 ticks of ringing
        write_slot(2'd2, 5'd12, 6'd0, 1'b1);
        tick_at(5'd12, 6'd0, 6'd0);
        checkOutput("s2_ring", 4'b0100, 1'b0);
        for (int s = 1; s < 60; s++) begin
            tick_at(5'd12, 6'd0, 6'(s));
        end
        checkOutput("s2_59_ticks", 4'b0100, 1'b0);
        tick_at(5'd12, 6'd1, 6'd0);
        checkOutput("s2_timeout", 4'b0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_pulse_one_cycle", 4'b0000, 1'b0);

        // Slots 0 and 3 at 06:00; clear beats snooze in the same cycle
        write_slot(2'd0, 5'd6, 6'd0, 1'b1);
        write_slot(2'd3, 5'd6, 6'd0, 1'b1);
        tick_at(5'd6, 6'd0, 6'd0);
        checkOutput("s03_ring", 4'b1001, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("s03_clear_wins", 4'b0000, 1'b0);
        tick_at(5'd6, 6'd9, 6'd0);
        checkOutput("s03_no_snooze_ring", 4'b0000, 1'b0);
        tick_at(5'd6, 6'd0, 6'd0);
        checkOutput("s03_next_day", 4'b1001, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Write to ringing slot 1 beats snooze; slot 3 snoozes to 07:39
        write_slot(2'd3, 5'd7, 6'd30, 1'b1);
        tick_at(5'd7, 6'd30, 6'd0);
        checkOutput("s13_ring", 4'b1010, 1'b0);
        set_write(2'd1, 5'd8, 6'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("s1_write_s3_snooze", 4'b0000, 1'b0);
        tick_at(5'd7, 6'd39, 6'd0);
        checkOutput("s3_snz_ring_0739", 4'b1000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("s3_clear", 4'b0000, 1'b0);
        tick_at(5'd8, 6'd0, 6'd0);
        checkOutput("s1_new_time_ring", 4'b0010, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset while slot 0 snoozed and slot 1 ringing
        write_slot(2'd1, 5'd6, 6'd5, 1'b1);
        tick_at(5'd6, 6'd0, 6'd0);
        checkOutput("s0_ring_0600", 4'b0001, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick_at(5'd6, 6'd5, 6'd0);
        checkOutput("s1_ring_0605", 4'b0010, 1'b0);
        rst_n = 1'b0;
        checkOutput("async_reset", 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick_at(5'd6, 6'd9, 6'd0);
        checkOutput("post_rst_snz_target", 4'b0000, 1'b0);
        tick_at(5'd6, 6'd5, 6'd0);
        checkOutput("post_rst_disarmed_s1", 4'b0000, 1'b0);
        tick_at(5'd6, 6'd0, 6'd0);
        checkOutput("post_rst_disarmed_s0", 4'b0000, 1'b0);

        if (exp_q.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
